// File: rtl/serial_alu_seq.sv
// -----------------------------------------------------------------------------
// serial_alu_seq
//
// Bit-serial ALU sequencer. One operation and two WIDTH-bit operands are
// accepted through a start/busy/done handshake. The single-bit datapath then
// walks the operands LSB first, one bit per clock, and assembles the result
// in a shift register that fills from the MSB side.
//
// Every per-bit operation is built from single-bit gate primitives (nand2,
// not1, and2, or2, xor2, mux2). These are written as functions so the file is
// self-contained. The full adder uses two xor2, two and2 and one or2. The op
// select is a tree of mux2 cells driven by op bits 0, 1, 2.
//
// Optional feature macro: SERIAL_ALU_SUB_EN
//   defined   : op 101 is SUB (a + ~b + 1). b goes through a per-bit not1
//               and the carry register is preset to 1 when the pass starts.
//   undefined : op 101 behaves like the reserved op (y=0, carry_out=0,
//               zero=1). The inverter path and carry preset are not built.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request. Sampled in IDLE or DONE; ignored while busy.
//   op[2:0]    in   000 AND, 001 OR, 010 XOR, 011 NOT a, 100 ADD,
//                   101 SUB, 110 PASS b, 111 reserved (result 0)
//   a, b       in   operands, latched together with op on an accepted start
//   busy       out  high while a bit-serial pass is running
//   done       out  one-cycle pulse. y/carry_out/zero are valid.
//   y          out  result, held until the next pass completes
//   carry_out  out  carry out of bit WIDTH-1 for ADD/SUB, 0 for other ops
//   zero       out  high when y == 0
//
// Every output comes from a register or is decoded from the state register.
// No input reaches an output through combinational logic only.
// -----------------------------------------------------------------------------
module serial_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             carry_out,
   output logic             zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // ------------------------------------------------------------------
   // Gate primitives. Every cell is built from nand2.
   // ------------------------------------------------------------------
   function automatic logic g_nand2(input logic i0, input logic i1);
      return ~(i0 & i1);
   endfunction

   function automatic logic g_not1(input logic i0);
      return g_nand2(i0, i0);
   endfunction

   function automatic logic g_and2(input logic i0, input logic i1);
      return g_not1(g_nand2(i0, i1));
   endfunction

   function automatic logic g_or2(input logic i0, input logic i1);
      return g_nand2(g_not1(i0), g_not1(i1));
   endfunction

   function automatic logic g_xor2(input logic i0, input logic i1);
      logic n;
      n = g_nand2(i0, i1);
      return g_nand2(g_nand2(i0, n), g_nand2(i1, n));
   endfunction

   // sel=0 selects i0, sel=1 selects i1
   function automatic logic g_mux2(input logic i0, input logic i1, input logic sel);
      return g_or2(g_and2(i0, g_not1(sel)), g_and2(i1, sel));
   endfunction

   // ------------------------------------------------------------------
   // State and registers
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;

   // ------------------------------------------------------------------
   // One-bit datapath for the bit selected by cnt
   // ------------------------------------------------------------------
   logic a_bit, b_bit, b_eff;
   logic fa_p, fa_g, fa_t, sum_bit, fa_cout;
   logic and_bit, or_bit, xor_bit, nota_bit, sub_sum_bit;
   logic m0_0, m0_1, m0_2, m0_3, m1_0, m1_1, res_bit;
   logic is_arith, carry_next, carry_preset;

   assign a_bit = a_q[cnt_q];
   assign b_bit = b_q[cnt_q];

`ifdef SERIAL_ALU_SUB_EN
   // op 101 is the only op with op[2]=1, op[1]=0, op[0]=1. The adder
   // sees ~b for SUB and the carry-in comes from the preset carry register.
   logic is_sub;
   assign is_sub       = g_and2(g_and2(op_q[2], g_not1(op_q[1])), op_q[0]);
   assign b_eff        = g_mux2(b_bit, g_not1(b_bit), is_sub);
   assign sub_sum_bit  = sum_bit;
   // ADD and SUB both keep their carry chain
   assign is_arith     = g_and2(op_q[2], g_not1(op_q[1]));
   assign carry_preset = (op == 3'b101);
`else
   assign b_eff        = b_bit;
   assign sub_sum_bit  = 1'b0;
   // Only ADD keeps its carry. Every other op forces the carry to 0.
   assign is_arith     = g_and2(g_and2(op_q[2], g_not1(op_q[1])), g_not1(op_q[0]));
   assign carry_preset = 1'b0;
`endif

   // Full adder: two xor2, two and2, one or2
   assign fa_p    = g_xor2(a_bit, b_eff);
   assign sum_bit = g_xor2(fa_p, carry_q);
   assign fa_g    = g_and2(a_bit, b_eff);
   assign fa_t    = g_and2(fa_p, carry_q);
   assign fa_cout = g_or2(fa_g, fa_t);

   // Logic ops use the raw b bit
   assign and_bit  = g_and2(a_bit, b_bit);
   assign or_bit   = g_or2(a_bit, b_bit);
   assign xor_bit  = g_xor2(a_bit, b_bit);
   assign nota_bit = g_not1(a_bit);

   // Op-select mux tree. Level 0 uses op[0], level 1 uses op[1],
   // and the root uses op[2].
   assign m0_0    = g_mux2(and_bit, or_bit, op_q[0]);       // 000 / 001
   assign m0_1    = g_mux2(xor_bit, nota_bit, op_q[0]);     // 010 / 011
   assign m0_2    = g_mux2(sum_bit, sub_sum_bit, op_q[0]);  // 100 / 101
   assign m0_3    = g_mux2(b_bit, 1'b0, op_q[0]);           // 110 / 111
   assign m1_0    = g_mux2(m0_0, m0_1, op_q[1]);
   assign m1_1    = g_mux2(m0_2, m0_3, op_q[1]);
   assign res_bit = g_mux2(m1_0, m1_1, op_q[2]);

   assign carry_next = g_and2(fa_cout, is_arith);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      shift_d = shift_q;
      y_d     = y_q;
      cout_d  = cout_q;
      zero_d  = zero_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               op_d    = op;
               a_d     = a;
               b_d     = b;
               carry_d = carry_preset;
               shift_d = '0;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            // New bit enters at the MSB. After WIDTH shifts, bit 0 has
            // moved down to position 0.
            shift_d = {res_bit, shift_q[WIDTH-1:1]};
            carry_d = carry_next;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               y_d     = shift_d;
               cout_d  = carry_next;
               zero_d  = (shift_d == '0);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         shift_q <= '0;
         y_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         shift_q <= shift_d;
         y_q     <= y_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign y         = y_q;
   assign carry_out = cout_q;
   assign zero      = zero_q;

endmodule
